atomik_state_reader: RTL and testbench
======================================

Name: atomik_state_reader

Overview:
- Read side of the delta accumulator. Reconstructs the current state as initial_state XOR delta_accumulator and serves it through a valid/ready request/response port.
- Converts an absolute target state back into a delta (target XOR current), optionally driving that delta into the accumulator's delta input.
- Sits between the host/command decoder and the accumulator. Is the only producer of the accumulator's delta_in and delta_valid.

Parameters:
- DELTA_WIDTH, 64, width of state, delta and data paths.
- TAG_WIDTH, 4, width of request tag echoed on the response.
- CNT_WIDTH, 16, width of the commit counter.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- initial_state_in  input  DELTA_WIDTH  initial state S0 from the accumulator
- delta_accumulator_in  input  DELTA_WIDTH  accumulated delta from the accumulator
- req_valid  input  1  request valid
- req_ready  output  1  request accepted when req_valid && req_ready at posedge
- req_op  input  2  00 READ, 01 DIFF, 10 DIFF_COMMIT, 11 reserved
- req_state  input  DELTA_WIDTH  target state for DIFF/DIFF_COMMIT (ignored for READ)
- req_tag  input  TAG_WIDTH  opaque tag
- resp_valid  output  1  response valid
- resp_ready  input  1  response consumed when resp_valid && resp_ready at posedge
- resp_data  output  DELTA_WIDTH  current state (READ) or delta (DIFF/DIFF_COMMIT)
- resp_tag  output  TAG_WIDTH  echoed req_tag
- resp_err  output  1  1 for reserved op
- delta_out  output  DELTA_WIDTH  delta to the accumulator's delta_in
- delta_valid  output  1  one-cycle strobe to the accumulator's delta_valid
- commit_count  output  CNT_WIDTH  number of DIFF_COMMITs issued

Behaviour:
- Reset values (rst high at posedge):
  - resp_valid=0, resp_data=0, resp_tag=0, resp_err=0.
  - delta_out=0, delta_valid=0, commit_count=0.
  - Response FIFO emptied; FSM to IDLE.
  - req_ready=0 while rst is high.
- Reset mid-operation: rst aborts everything. A pending delta_valid strobe drops at the reset edge. Queued responses are discarded, not delivered.
- current = initial_state_in ^ delta_accumulator_in. It is sampled combinationally in the acceptance cycle only; later changes do not affect an accepted request.
- Result per op:
  - READ: result=current.
  - DIFF, DIFF_COMMIT: result=req_state ^ current.
  - Reserved op: result=0, resp_err=1, no side effects.
- Response buffer: 2-entry in-order FIFO holding {data, tag, err}.
  - Accepted request writes the FIFO at the acceptance edge. The head is visible on resp_* from the next cycle, so latency is 1 cycle with an empty FIFO.
  - Simultaneous push and pop in the same cycle are legal; occupancy is unchanged.
  - resp_* hold stable while resp_valid && !resp_ready.
  - resp_data/resp_tag/resp_err are don't-care while resp_valid=0.
- req_ready = (fifo_count < 2) && state==IDLE && !rst. It is registered-path only, with no combinational dependency on resp_ready.
- FSM states IDLE and COMMIT:
  - IDLE: on acceptance of DIFF_COMMIT, go to COMMIT. Register delta_out=result and assert delta_valid=1 for exactly the COMMIT cycle. Increment commit_count (wraps modulo 2^CNT_WIDTH).
  - COMMIT: req_ready=0 (stall). Return to IDLE unconditionally next cycle; delta_valid returns to 0.
  - The stall guarantees the accumulator has applied the delta before the next request samples current, so read-after-commit never sees stale state.
- DIFF never touches delta_out/delta_valid. delta_out holds its last value while delta_valid=0.
- After a DIFF_COMMIT with target T completes, a READ returns T, provided no other accumulator activity occurs.
- Back-to-back DIFF_COMMITs are spaced by at least one stall cycle, giving max commit throughput of 1 per 2 cycles. READ/DIFF throughput is 1 per cycle when resp_ready=1.
- Accepting a request when the FIFO is full is impossible by construction (req_ready=0).

Test Plan:
- Reset: hold rst=1 for 3 cycles with req_valid=1 -> req_ready=0, resp_valid=0, delta_valid=0, commit_count=0. Cycle after release -> req_ready=1.
- READ: S0=0x00FF, acc=0x0F0F, tag=3, accepted at edge N -> cycle N+1 resp_valid=1, resp_data=0x0FF0, resp_tag=3, resp_err=0, delta_valid stays 0.
- DIFF_COMMIT, target 0xAAAA, current 0x0FF0, bench accumulator model connected:
  - Next cycle: delta_out=0xA55A, delta_valid=1 for one cycle, req_ready=0, commit_count=1, resp_data=0xA55A.
  - Immediate following READ -> resp_data=0xAAAA.
- Backpressure: resp_ready=0, issue READs with tags 1,2,3 -> two accepted, req_ready=0, tag 3 held off. Raise resp_ready -> responses tags 1,2,3 in order, data stable while stalled.
- Reserved op 11, tag 7 -> resp_err=1, resp_data=0, resp_tag=7, no delta_valid, commit_count unchanged.
- Reset mid-commit: assert rst in the COMMIT cycle with one response queued -> at the next cycle delta_valid=0, resp_valid=0, commit_count=0, FIFO empty.

Source files
------------

// File: rtl/atomik_state_reader.sv
// Read side of the delta accumulator: serves current state (S0 ^ acc), converts
// absolute targets into deltas and optionally commits them back to the accumulator.
module atomik_state_reader #(
    parameter int DELTA_WIDTH = 64,
    parameter int TAG_WIDTH   = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DELTA_WIDTH-1:0] initial_state_in,
    input  logic [DELTA_WIDTH-1:0] delta_accumulator_in,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [1:0]             req_op,
    input  logic [DELTA_WIDTH-1:0] req_state,
    input  logic [TAG_WIDTH-1:0]   req_tag,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [DELTA_WIDTH-1:0] resp_data,
    output logic [TAG_WIDTH-1:0]   resp_tag,
    output logic                   resp_err,
    output logic [DELTA_WIDTH-1:0] delta_out,
    output logic                   delta_valid,
    output logic [CNT_WIDTH-1:0]   commit_count
);

    localparam logic [1:0] OP_READ   = 2'b00;
    localparam logic [1:0] OP_DIFF   = 2'b01;
    localparam logic [1:0] OP_COMMIT = 2'b10;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_COMMIT = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [DELTA_WIDTH-1:0] r_fifo_data [2];
    logic [TAG_WIDTH-1:0]   r_fifo_tag  [2];
    logic [1:0]             r_fifo_err;
    logic                   r_rd_ptr;
    logic                   r_wr_ptr;
    logic [1:0]             r_count;

    logic [DELTA_WIDTH-1:0] r_delta_out;
    logic                   r_delta_valid;
    logic [CNT_WIDTH-1:0]   r_commit_count;

    logic [DELTA_WIDTH-1:0] w_current;
    logic [DELTA_WIDTH-1:0] w_result;
    logic                   w_err;
    logic                   w_is_commit;
    logic                   w_req_ready;
    logic                   w_accept;
    logic                   w_pop;

    // Current state is only meaningful in the acceptance cycle; the result is latched into the FIFO.
    assign w_current   = initial_state_in ^ delta_accumulator_in;
    // Stalling in COMMIT lets the accumulator absorb the delta before the next sample of current.
    assign w_req_ready = (r_count < 2'd2) && (r_state == ST_IDLE) && !rst;
    assign w_accept    = req_valid && w_req_ready;
    assign w_pop       = (r_count != 2'd0) && resp_ready;

    // Per-op result, error flag and commit qualifier
    always_comb begin
        w_result    = '0;
        w_err       = 1'b0;
        w_is_commit = 1'b0;
        case (req_op)
            OP_READ: begin
                w_result = w_current;
            end
            OP_DIFF: begin
                w_result = req_state ^ w_current;
            end
            OP_COMMIT: begin
                w_result    = req_state ^ w_current;
                w_is_commit = 1'b1;
            end
            default: begin
                w_result = '0;
                w_err    = 1'b1;
            end
        endcase
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_is_commit) begin
                    w_state_nxt = ST_COMMIT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Commit strobe, held delta and commit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_delta_out    <= '0;
            r_delta_valid  <= 1'b0;
            r_commit_count <= '0;
        end else begin
            r_delta_valid <= w_accept && w_is_commit;
            if (w_accept && w_is_commit) begin
                r_delta_out    <= w_result;
                r_commit_count <= r_commit_count + CNT_WIDTH'(1);
            end
        end
    end

    // Two-entry in-order response FIFO; push and pop in one cycle keep occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_tag[i]  <= '0;
            end
            r_fifo_err <= 2'b00;
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_count    <= 2'd0;
        end else begin
            if (w_accept) begin
                r_fifo_data[r_wr_ptr] <= w_result;
                r_fifo_tag[r_wr_ptr]  <= req_tag;
                r_fifo_err[r_wr_ptr]  <= w_err;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign req_ready    = w_req_ready;
    assign resp_valid   = (r_count != 2'd0);
    assign resp_data    = r_fifo_data[r_rd_ptr];
    assign resp_tag     = r_fifo_tag[r_rd_ptr];
    assign resp_err     = r_fifo_err[r_rd_ptr];
    assign delta_out    = r_delta_out;
    assign delta_valid  = r_delta_valid;
    assign commit_count = r_commit_count;

endmodule

// File: tb/tb_atomik_state_reader.sv
// Scoreboard bench for atomik_state_reader with a small XOR accumulator model.
module tb_atomik_state_reader;

    localparam int DW = 64;
    localparam int TW = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s0;
    logic [DW-1:0] acc_base;
    logic [DW-1:0] acc_delta = '0;
    logic [DW-1:0] delta_accumulator_in;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [DW-1:0] req_state;
    logic [TW-1:0] req_tag;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_data;
    logic [TW-1:0] resp_tag;
    logic          resp_err;
    logic [DW-1:0] delta_out;
    logic          delta_valid;
    logic [CW-1:0] commit_count;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
        logic          err;
    } resp_t;

    resp_t sb[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    always #5 clk = ~clk;

    atomik_state_reader #(.DELTA_WIDTH(DW), .TAG_WIDTH(TW), .CNT_WIDTH(CW)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .initial_state_in     (s0),
        .delta_accumulator_in (delta_accumulator_in),
        .req_valid            (req_valid),
        .req_ready            (req_ready),
        .req_op               (req_op),
        .req_state            (req_state),
        .req_tag              (req_tag),
        .resp_valid           (resp_valid),
        .resp_ready           (resp_ready),
        .resp_data            (resp_data),
        .resp_tag             (resp_tag),
        .resp_err             (resp_err),
        .delta_out            (delta_out),
        .delta_valid          (delta_valid),
        .commit_count         (commit_count)
    );

    // Accumulator model: base set by the bench, committed deltas folded in on the strobe
    assign delta_accumulator_in = acc_base ^ acc_delta;
    always @(posedge clk) begin
        if (delta_valid) acc_delta <= acc_delta ^ delta_out;
    end

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    function automatic resp_t model(input logic [1:0] op, input logic [DW-1:0] st,
                                    input logic [TW-1:0] tag, input logic [DW-1:0] cur);
        resp_t r;
        r.tag = tag;
        r.err = 1'b0;
        case (op)
            2'b00:   r.data = cur;
            2'b01,
            2'b10:   r.data = st ^ cur;
            default: begin r.data = '0; r.err = 1'b1; end
        endcase
        return r;
    endfunction

    // Scoreboard: push on acceptance, pop and compare on delivery; reset discards everything
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_resp_without_request", DW'(sb.size()), 64'd1);
                end else begin
                    resp_t e;
                    e = sb.pop_front();
                    chk("sb_data", resp_data, e.data);
                    chk("sb_tag", DW'(resp_tag), DW'(e.tag));
                    chk("sb_err", DW'(resp_err), DW'(e.err));
                end
            end
            if (req_valid && req_ready)
                sb.push_back(model(req_op, req_state, req_tag, s0 ^ delta_accumulator_in));
        end
    end

    // Drive one request from posedge+1, wait (bounded) for acceptance, then drop req_valid
    task automatic issue(input logic [1:0] op, input logic [DW-1:0] st, input logic [TW-1:0] tag);
        int n;
        n = 0;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_op    = op;
        req_state = st;
        req_tag   = tag;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("accept_timeout", DW'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst        = 1'b1;
        req_valid  = 1'b1;
        req_op     = 2'b00;
        req_state  = '0;
        req_tag    = '0;
        resp_ready = 1'b1;
        s0         = '0;
        acc_base   = '0;

        repeat (3) begin
            @(negedge clk);
            chk("rst_req_ready", DW'(req_ready), 64'd0);
            chk("rst_resp_valid", DW'(resp_valid), 64'd0);
            chk("rst_delta_valid", DW'(delta_valid), 64'd0);
            chk("rst_commit_count", DW'(commit_count), 64'd0);
        end
        @(posedge clk); #1;
        rst       = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", DW'(req_ready), 64'd1);

        // READ with one-cycle latency
        s0       = 64'h00FF;
        acc_base = 64'h0F0F;
        issue(2'b00, 64'h0, 4'd3);
        @(negedge clk);
        chk("read_valid", DW'(resp_valid), 64'd1);
        chk("read_data", resp_data, 64'h0FF0);
        chk("read_tag", DW'(resp_tag), 64'd3);
        chk("read_err", DW'(resp_err), 64'd0);
        chk("read_no_delta", DW'(delta_valid), 64'd0);

        // DIFF_COMMIT then immediate READ sees the target
        issue(2'b10, 64'hAAAA, 4'd5);
        @(negedge clk);
        chk("commit_delta_out", delta_out, 64'hA55A);
        chk("commit_delta_valid", DW'(delta_valid), 64'd1);
        chk("commit_stall", DW'(req_ready), 64'd0);
        chk("commit_count1", DW'(commit_count), 64'd1);
        chk("commit_resp_data", resp_data, 64'hA55A);
        issue(2'b00, 64'h0, 4'd6);
        @(negedge clk);
        chk("read_after_commit", resp_data, 64'hAAAA);
        chk("strobe_one_cycle", DW'(delta_valid), 64'd0);

        // DIFF leaves the commit path alone
        issue(2'b01, 64'h1234, 4'd4);
        @(negedge clk);
        chk("diff_data", resp_data, 64'hB89E);
        chk("diff_no_strobe", DW'(delta_valid), 64'd0);
        chk("diff_delta_held", delta_out, 64'hA55A);
        chk("diff_count_held", DW'(commit_count), 64'd1);

        // Back-to-back READ/DIFF at full rate (simultaneous push/pop)
        @(posedge clk); #1;
        req_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req_op    = 2'(i % 2);
            req_state = {$urandom, $urandom};
            req_tag   = TW'(i + 8);
            @(negedge clk);
            chk("b2b_ready", DW'(req_ready), 64'd1);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;

        // Backpressure: two queued, third held off, data stable, in-order drain
        @(posedge clk); #1;
        resp_ready = 1'b0;
        issue(2'b00, 64'h0, 4'd1);
        issue(2'b00, 64'h0, 4'd2);
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_tag   = 4'd3;
        acc_base  = 64'h5555;
        repeat (3) begin
            @(negedge clk);
            chk("bp_req_ready", DW'(req_ready), 64'd0);
            chk("bp_resp_valid", DW'(resp_valid), 64'd1);
            chk("bp_head_tag", DW'(resp_tag), 64'd1);
            chk("bp_head_data", resp_data, 64'hAAAA);
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("bp_accept_timeout", DW'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("bp_drained", DW'(sb.size()), 64'd0);

        // Reserved op
        issue(2'b11, 64'hFFFF, 4'd7);
        @(negedge clk);
        chk("rsv_err", DW'(resp_err), 64'd1);
        chk("rsv_data", resp_data, 64'h0);
        chk("rsv_tag", DW'(resp_tag), 64'd7);
        chk("rsv_no_strobe", DW'(delta_valid), 64'd0);
        chk("rsv_count_held", DW'(commit_count), 64'd1);

        // Reset in the COMMIT cycle with a response queued
        @(posedge clk); #1;
        resp_ready = 1'b0;
        issue(2'b00, 64'h0, 4'd8);
        issue(2'b10, 64'h0, 4'd9);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("mid_rst_delta_valid", DW'(delta_valid), 64'd0);
        chk("mid_rst_resp_valid", DW'(resp_valid), 64'd0);
        chk("mid_rst_commit_count", DW'(commit_count), 64'd0);
        chk("mid_rst_req_ready", DW'(req_ready), 64'd0);
        @(posedge clk); #1;
        rst        = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        chk("after_rst_fifo_empty", DW'(resp_valid), 64'd0);
        chk("after_rst_req_ready", DW'(req_ready), 64'd1);
        issue(2'b00, 64'h0, 4'd10);
        repeat (3) @(negedge clk);
        chk("final_drained", DW'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
